// File: rtl/atan_sched.sv
// rtl/atan_sched.sv - round-robin issue scheduler for a shared fixed-latency atan pipeline
module atan_sched #(
   parameter int NCH = 4,
   parameter int CW  = 2,
   parameter int LAT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NCH-1:0]    req_valid,
   input  logic [NCH*21-1:0] req_log,
   output logic [NCH-1:0]    req_ready,
   output logic [20:0]       pipe_log,
   input  logic [19:0]       pipe_out,
   output logic              res_valid,
   output logic [CW-1:0]     res_chan,
   output logic [19:0]       res_data,
   output logic              busy
);

   localparam int LW = 21;
   localparam int RW = 20;

   logic [CW-1:0]  ptr_q, ptr_d;
   logic [LAT-1:0] tag_vld_q;
   logic [CW-1:0]  tag_chan_q [LAT];
   logic           res_valid_q, res_valid_d;
   logic [CW-1:0]  res_chan_q, res_chan_d;
   logic [RW-1:0]  res_data_q, res_data_d;

   logic [LW-1:0]  log_arr [NCH];
   logic           gnt_found;
   logic [CW-1:0]  gnt;
   logic [CW-1:0]  cand;
   logic           hs;

   // Split the flat request bus into one word per channel
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         log_arr[i] = req_log[i*LW +: LW];
      end
   end

   // Circular priority search starting at the round-robin pointer; no grant during reset
   always_comb begin
      gnt_found = 1'b0;
      gnt       = '0;
      cand      = '0;
      for (int k = 0; k < NCH; k++) begin
         cand = CW'((int'(ptr_q) + k) % NCH);
         if (!gnt_found && req_valid[cand]) begin
            gnt_found = 1'b1;
            gnt       = cand;
         end
      end
      hs        = gnt_found & ~rst;
      req_ready = '0;
      if (hs) begin
         req_ready[gnt] = 1'b1;
      end
      pipe_log = hs ? log_arr[gnt] : '0;
      ptr_d    = hs ? CW'((int'(gnt) + 1) % NCH) : ptr_q;
   end

   // Round-robin pointer advances past the channel just served
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   // Tag shift register mirrors the pipeline depth; it never stalls
   always_ff @(posedge clk) begin
      if (rst) begin
         tag_vld_q <= '0;
         for (int i = 0; i < LAT; i++) begin
            tag_chan_q[i] <= '0;
         end
      end else begin
         tag_vld_q     <= {tag_vld_q[LAT-2:0], hs};
         tag_chan_q[0] <= gnt;
         for (int i = 1; i < LAT; i++) begin
            tag_chan_q[i] <= tag_chan_q[i-1];
         end
      end
   end

   // Capture the pipeline result when the oldest tag is valid; hold data otherwise
   always_comb begin
      res_valid_d = tag_vld_q[LAT-1];
      res_chan_d  = res_chan_q;
      res_data_d  = res_data_q;
      if (tag_vld_q[LAT-1]) begin
         res_chan_d = tag_chan_q[LAT-1];
         res_data_d = pipe_out;
      end
   end

   // Registered result outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         res_valid_q <= 1'b0;
         res_chan_q  <= '0;
         res_data_q  <= '0;
      end else begin
         res_valid_q <= res_valid_d;
         res_chan_q  <= res_chan_d;
         res_data_q  <= res_data_d;
      end
   end

   assign res_valid = res_valid_q;
   assign res_chan  = res_chan_q;
   assign res_data  = res_data_q;
   assign busy      = (|tag_vld_q) | res_valid_q;

endmodule

// File: tb/tb_atan_sched.sv
// tb/tb_atan_sched.sv - directed self-checking bench for atan_sched
module tb_atan_sched;

   localparam int NCH = 4;
   localparam int CW  = 2;
   localparam int LAT = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [NCH-1:0]    req_valid;
   logic [NCH*21-1:0] req_log;
   logic [NCH-1:0]    req_ready;
   logic [20:0]       pipe_log;
   logic [19:0]       pipe_out;
   logic              res_valid;
   logic [CW-1:0]     res_chan;
   logic [19:0]       res_data;
   logic              busy;

   int n_assert = 0;
   int n_fail   = 0;

   logic [19:0] pm [LAT];
   logic [20:0] w [NCH];

   atan_sched #(.NCH(NCH), .CW(CW), .LAT(LAT)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_log   (req_log),
      .req_ready (req_ready),
      .pipe_log  (pipe_log),
      .pipe_out  (pipe_out),
      .res_valid (res_valid),
      .res_chan  (res_chan),
      .res_data  (res_data),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [19:0] f(input logic [20:0] x);
      return x[19:0] ^ {x[20], 19'h35A5A};
   endfunction

   // Stand-in for the shared atan pipeline: LAT-deep delay of f(pipe_log)
   always @(posedge clk) begin
      pm[0] <= f(pipe_log);
      for (int i = 1; i < LAT; i++) pm[i] <= pm[i-1];
   end
   assign pipe_out = pm[LAT-1];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_log(input int ch, input logic [20:0] v);
      req_log[ch*21 +: 21] = v;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      req_valid = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < LAT; i++) pm[i] = '0;
      w[0] = 21'h00011;
      w[1] = 21'h01122;
      w[2] = 21'h12233;
      w[3] = 21'h1F344;
      rst       = 1'b1;
      req_valid = '0;
      req_log   = '0;

      // Reset: no grant while rst=1 even with all channels requesting
      tick();
      tick();
      req_valid = 4'hF;
      req_log   = {NCH*21{1'b1}};
      #1;
      chk("rst_ready", 64'(req_ready), 64'(4'h0));
      chk("rst_pipe_log", 64'(pipe_log), 64'(21'h0));
      chk("rst_res_valid", 64'(res_valid), 64'(1'b0));
      chk("rst_res_chan", 64'(res_chan), 64'(2'd0));
      chk("rst_res_data", 64'(res_data), 64'(20'h0));
      chk("rst_busy", 64'(busy), 64'(1'b0));

      // Single request on channel 2
      do_reset();
      req_valid = 4'b0100;
      set_log(2, 21'h00800);
      #1;
      chk("s1_ready", 64'(req_ready), 64'(4'b0100));
      chk("s1_pipe_log", 64'(pipe_log), 64'(21'h00800));
      for (int n = 1; n <= 6; n++) begin
         tick();
         req_valid = '0;
         #1;
         chk($sformatf("s1_res_valid_c%0d", n), 64'(res_valid), 64'(n == 5));
         if (n == 1) chk("s1_busy_c1", 64'(busy), 64'(1'b1));
         if (n == 5) begin
            chk("s1_res_chan", 64'(res_chan), 64'(2'd2));
            chk("s1_res_data", 64'(res_data), 64'(f(21'h00800)));
         end
      end

      // All channels continuously requesting for 8 cycles
      do_reset();
      for (int c = 0; c < NCH; c++) set_log(c, w[c]);
      for (int n = 0; n <= 12; n++) begin
         if (n > 0) tick();
         req_valid = (n < 8) ? 4'hF : 4'h0;
         #1;
         chk($sformatf("s2_ready_c%0d", n), 64'(req_ready),
             64'((n < 8) ? (4'b0001 << (n % 4)) : 4'b0000));
         if (n < 8) chk($sformatf("s2_pipe_log_c%0d", n), 64'(pipe_log), 64'(w[n % 4]));
         chk($sformatf("s2_res_valid_c%0d", n), 64'(res_valid), 64'(n >= 5));
         if (n >= 5) begin
            chk($sformatf("s2_res_chan_c%0d", n), 64'(res_chan), 64'((n - 5) % 4));
            chk($sformatf("s2_res_data_c%0d", n), 64'(res_data), 64'(f(w[(n - 5) % 4])));
         end
      end

      // Pointer wrap: after granting 2, channel 3 wins over channel 0, then 0
      do_reset();
      req_valid = 4'b0100;
      #1;
      chk("s3_ready_c0", 64'(req_ready), 64'(4'b0100));
      tick();
      req_valid = 4'b1001;
      #1;
      chk("s3_ready_c1", 64'(req_ready), 64'(4'b1000));
      tick();
      #1;
      chk("s3_ready_c2", 64'(req_ready), 64'(4'b0001));
      tick();
      req_valid = '0;

      // Sparse traffic: channel 1 on cycles 0, 3 and 4
      do_reset();
      set_log(1, 21'h0C0DE);
      for (int n = 0; n <= 10; n++) begin
         if (n > 0) tick();
         req_valid = (n == 0 || n == 3 || n == 4) ? 4'b0010 : 4'b0000;
         #1;
         chk($sformatf("s4_res_valid_c%0d", n), 64'(res_valid),
             64'(n == 5 || n == 8 || n == 9));
         if (n == 9) chk("s4_busy_c9", 64'(busy), 64'(1'b1));
         if (n == 9) chk("s4_res_chan_c9", 64'(res_chan), 64'(2'd1));
      end
      chk("s4_busy_c10", 64'(busy), 64'(1'b0));

      // Reset mid-flight: in-flight tags are discarded
      do_reset();
      set_log(0, 21'h13579);
      for (int n = 0; n <= 10; n++) begin
         if (n > 0) tick();
         req_valid = (n <= 2) ? 4'b0001 : 4'b0000;
         rst       = (n == 3);
         #1;
         if (n == 3) chk("s5_ready_in_rst", 64'(req_ready), 64'(4'b0000));
         if (n >= 4) begin
            chk($sformatf("s5_res_valid_c%0d", n), 64'(res_valid), 64'(1'b0));
            chk($sformatf("s5_busy_c%0d", n), 64'(busy), 64'(1'b0));
         end
      end

      // Reset mid-flight followed by a new request in the first cycle out of reset
      do_reset();
      set_log(1, 21'h02468);
      set_log(3, 21'h0ABCD);
      for (int n = 0; n <= 10; n++) begin
         if (n > 0) tick();
         req_valid = (n <= 2) ? 4'b0010 : ((n == 4) ? 4'b1000 : 4'b0000);
         rst       = (n == 3);
         #1;
         if (n == 4) chk("s6_ready_c4", 64'(req_ready), 64'(4'b1000));
         chk($sformatf("s6_res_valid_c%0d", n), 64'(res_valid), 64'(n == 9));
         if (n == 9) begin
            chk("s6_res_chan", 64'(res_chan), 64'(2'd3));
            chk("s6_res_data", 64'(res_data), 64'(f(21'h0ABCD)));
         end
      end
      rst = 1'b0;

      // Idle: nothing issued for 20 cycles and the pointer is preserved
      do_reset();
      set_log(1, 21'h0F0F0);
      req_valid = 4'b0010;
      #1;
      chk("s7_ready_c0", 64'(req_ready), 64'(4'b0010));
      for (int n = 1; n <= 20; n++) begin
         tick();
         req_valid = '0;
         req_log   = {NCH*21{1'b1}};
         #1;
         chk($sformatf("s7_ready_c%0d", n), 64'(req_ready), 64'(4'b0000));
         chk($sformatf("s7_pipe_log_c%0d", n), 64'(pipe_log), 64'(21'h0));
         chk($sformatf("s7_res_valid_c%0d", n), 64'(res_valid), 64'(n == 5));
      end
      tick();
      req_valid = 4'hF;
      #1;
      chk("s7_ptr_kept", 64'(req_ready), 64'(4'b0100));
      tick();
      req_valid = '0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/atan_sched.md
Name: atan_sched

Overview:
- Round-robin scheduler that shares one fixed-latency atan(log2(y/x)) LUT/interpolation pipeline between NCH requesting channels.
- Each channel submits a 21-bit log-ratio word with a valid/ready handshake.
- The block issues at most one word per cycle into the pipeline and tracks the channel ID alongside it in a tag shift register.
- It returns each 20-bit result tagged with its originating channel; it sits between the per-channel ratio/log stages and the shared atan pipeline.

Parameters:
- NCH, 4, number of requesting channels (2..16).
- CW, 2, channel ID width, equal to clog2(NCH).
- LAT, 4, fixed pipeline latency in cycles, from the edge that samples pipe_log to the cycle pipe_out is valid.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NCH  per-channel request valid.
- req_log  in  NCH*21  per-channel log word; channel i occupies bits [21*i+20 : 21*i].
- req_ready  out  NCH  per-channel accept; one-hot or zero.
- pipe_log  out  21  word driven into the shared atan pipeline input.
- pipe_out  in  20  atan pipeline result.
- res_valid  out  1  result valid (registered).
- res_chan  out  CW  channel ID of the result (registered).
- res_data  out  20  result value (registered).
- busy  out  1  at least one issue in flight or a result pending this cycle.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - res_valid=0, res_chan=0, res_data=0, busy=0.
  - All tag-valid bits cleared.
  - Round-robin pointer = 0.
  - req_ready is combinational and is 0 while rst=1.
- Arbitration (combinational):
  - Grant the lowest channel index >= ptr (circular, wrapping NCH-1 -> 0) with req_valid=1.
  - req_ready[g]=1 only for the granted channel g. A handshake occurs when req_valid[g]&req_ready[g].
- Pointer update: on a handshake, ptr <= (g+1) mod NCH on the next edge. With no request, ptr holds.
- Issue path:
  - pipe_log = req_log of the granted channel during the handshake cycle; 21'd0 otherwise.
  - Combinational; the pipeline samples it on the same edge.
- Tag pipeline:
  - LAT-stage shift register of {valid, chan}. Stage 0 loads {handshake, g} at the edge; entries shift every cycle unconditionally.
  - The pipeline cannot stall, so there is no output backpressure.
- Output:
  - When the stage LAT-1 tag is valid, pipe_out is the result for that tag. On the next edge: res_valid<=1, res_chan<=tag chan, res_data<=pipe_out.
  - Otherwise res_valid<=0, and res_chan/res_data hold their previous values.
  - Total latency: handshake at cycle T -> res_valid high in cycle T+LAT+1, exactly 1 cycle wide per request.
- Throughput: 1 result per cycle sustained. Results leave in issue order; every accepted word produces exactly one result.
- Fairness: with all channels continuously requesting, grant order is 0,1,..,NCH-1,0,...; no channel waits more than NCH-1 cycles once its valid is high.
- busy = OR of all tag-valid bits OR res_valid.
- Reset mid-operation: all in-flight tags are discarded. Pipeline data emerging after reset produces no res_valid. Issue may resume in the first cycle with rst=0.
- Requester rule: req_log must be stable while req_valid=1 and not yet accepted. Dropping req_valid without a handshake is permitted; that request is lost without a result.

Test Plan:
- Single request: after reset, req_valid[2]=1 with log=21'h0_0800 at cycle 0.
  - req_ready[2]=1 in cycle 0 and pipe_log=21'h0_0800.
  - Model pipe_out as a LAT-deep delay of a known function; res_valid=1 at cycle 5 with res_chan=2 and the matching data, then res_valid=0 at cycle 6.
- All four channels valid continuously for 8 cycles with distinct log words:
  - Grants are 0,1,2,3,0,1,2,3 and each req_ready is one-hot.
  - res_chan sequence is 0,1,2,3,0,1,2,3 in cycles 5..12, with data matching each channel's words.
- Pointer wrap: ptr=3 after granting channel 2; channels 0 and 3 both valid -> grant 3 first, then 0 next cycle.
- Sparse traffic: channel 1 requests on cycles 0, 3 and 4 only.
  - res_valid pulses on cycles 5, 8 and 9 only.
  - busy deasserts at cycle 10.
- Reset mid-flight: issue on cycles 0..2, assert rst in cycle 3.
  - res_valid stays 0 through cycle 10 and busy=0 from cycle 4.
  - A new request at cycle 4 returns at cycle 9 with the correct channel.
- Idle behaviour: no valids for 20 cycles -> pipe_log=0, req_ready=0, res_valid=0, ptr unchanged.
